// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: 32-bit frame, LSB first, carrier-modulated LED drive, 108 ms frame period.
// Optional repeat-code generation while a key is held is enabled by defining IR_TX_REPEAT_EN.
module ir_nec_tx #(
    parameter int UNIT_CYC = 15187,
    parameter int CAR_HALF = 355
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] tx_data,
    input  logic        tx_start,
    input  logic        tx_hold,
    output logic        ir_out,
    output logic        ir_env,
    output logic        busy,
    output logic        done
);
    // state       | meaning
    // IDLE        | waiting for tx_start
    // LEAD_MARK   | 16u leader burst
    // LEAD_SPACE  | 8u leader space
    // BIT_MARK    | 1u burst before every data bit
    // BIT_SPACE   | 1u (bit=0) or 3u (bit=1) space
    // STOP_MARK   | 1u trailing burst
    // GAP         | silence until 192u since frame start
    // REP_MARK    | 16u repeat-code burst
    // REP_SPACE   | 4u repeat-code space
    // REP_STOP    | 1u repeat-code trailing burst
    // REP_GAP     | silence until 192u since repeat start
    localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int CW = (CAR_HALF > 1) ? $clog2(CAR_HALF) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYC - 1);
    localparam logic [CW-1:0] CAR_LAST  = CW'(CAR_HALF - 1);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LEAD_MARK  = 4'd1;
    localparam logic [3:0] S_LEAD_SPACE = 4'd2;
    localparam logic [3:0] S_BIT_MARK   = 4'd3;
    localparam logic [3:0] S_BIT_SPACE  = 4'd4;
    localparam logic [3:0] S_STOP_MARK  = 4'd5;
    localparam logic [3:0] S_GAP        = 4'd6;
`ifdef IR_TX_REPEAT_EN
    localparam logic [3:0] S_REP_MARK   = 4'd7;
    localparam logic [3:0] S_REP_SPACE  = 4'd8;
    localparam logic [3:0] S_REP_STOP   = 4'd9;
    localparam logic [3:0] S_REP_GAP    = 4'd10;
`else
    logic w_unused_hold;
    assign w_unused_hold = tx_hold;
`endif

    logic [3:0]    r_state, w_next;
    logic [UW-1:0] r_unit;
    logic [4:0]    r_dur, w_len;
    logic [7:0]    r_frm;
    logic [31:0]   r_shift;
    logic [4:0]    r_bit;
    logic [CW-1:0] r_car_cnt, w_car_cnt;
    logic          r_car, w_car;
    logic          w_tick, w_dur_end, w_frm_end, w_done, w_cur_mark, w_next_mark;

    function automatic logic is_mark(input logic [3:0] s);
        logic m;
        m = (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
`ifdef IR_TX_REPEAT_EN
        m = m || (s == S_REP_MARK) || (s == S_REP_STOP);
`endif
        return m;
    endfunction

    always_comb begin
        w_len = 5'd1;
        case (r_state)
            S_LEAD_MARK:  w_len = 5'd16;
            S_LEAD_SPACE: w_len = 5'd8;
            S_BIT_SPACE:  w_len = r_shift[0] ? 5'd3 : 5'd1;
`ifdef IR_TX_REPEAT_EN
            S_REP_MARK:   w_len = 5'd16;
            S_REP_SPACE:  w_len = 5'd4;
`endif
            default:      w_len = 5'd1;
        endcase
    end

    assign w_tick    = (r_state != S_IDLE) && (r_unit == UNIT_LAST);
    assign w_dur_end = w_tick && (r_dur == w_len - 5'd1);
    assign w_frm_end = w_tick && (r_frm == 8'd191);

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:       if (tx_start) w_next = S_LEAD_MARK;
            S_LEAD_MARK:  if (w_dur_end) w_next = S_LEAD_SPACE;
            S_LEAD_SPACE: if (w_dur_end) w_next = S_BIT_MARK;
            S_BIT_MARK:   if (w_dur_end) w_next = S_BIT_SPACE;
            S_BIT_SPACE:  if (w_dur_end) w_next = (r_bit == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            S_STOP_MARK:  if (w_dur_end) w_next = S_GAP;
`ifdef IR_TX_REPEAT_EN
            S_GAP, S_REP_GAP: begin
                if (w_frm_end) begin
                    if (tx_hold) begin
                        w_next = S_REP_MARK;
                    end else begin
                        w_next = S_IDLE;
                        w_done = 1'b1;
                    end
                end
            end
            S_REP_MARK:   if (w_dur_end) w_next = S_REP_SPACE;
            S_REP_SPACE:  if (w_dur_end) w_next = S_REP_STOP;
            S_REP_STOP:   if (w_dur_end) w_next = S_REP_GAP;
`else
            S_GAP: begin
                if (w_frm_end) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
`endif
            default:      w_next = S_IDLE;
        endcase
    end

    // Every mark is entered from a non-mark state, so the carrier restarts high on each burst.
    assign w_cur_mark  = is_mark(r_state);
    assign w_next_mark = is_mark(w_next);

    always_comb begin
        w_car     = 1'b0;
        w_car_cnt = '0;
        if (w_next_mark && !w_cur_mark) begin
            w_car = 1'b1;
        end else if (w_cur_mark) begin
            if (r_car_cnt == CAR_LAST) begin
                w_car = ~r_car;
            end else begin
                w_car     = r_car;
                w_car_cnt = r_car_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_unit    <= '0;
            r_dur     <= '0;
            r_frm     <= '0;
            r_shift   <= '0;
            r_bit     <= '0;
            r_car_cnt <= '0;
            r_car     <= 1'b0;
            ir_out    <= 1'b0;
            ir_env    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_car_cnt <= w_car_cnt;
            r_car     <= w_car;
            if (r_state == S_IDLE || w_tick) r_unit <= '0;
            else                             r_unit <= r_unit + UW'(1);
            if (w_next != r_state) r_dur <= '0;
            else if (w_tick)       r_dur <= r_dur + 5'd1;
            if (r_state == S_IDLE || w_frm_end) r_frm <= '0;
            else if (w_tick)                    r_frm <= r_frm + 8'd1;
            if (r_state == S_IDLE && tx_start) begin
                r_shift <= tx_data;
                r_bit   <= '0;
            end else if (r_state == S_BIT_SPACE && w_dur_end) begin
                r_shift <= r_shift >> 1;
                r_bit   <= r_bit + 5'd1;
            end
            ir_env <= w_next_mark;
            ir_out <= w_next_mark & w_car;
            busy   <= (w_next != S_IDLE);
            done   <= w_done;
        end
    end
endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: cycle-level model of the NEC waveform built from mark/space timing rules,
// a table of frames with hand-derived envelope lengths, random frames, and corner-case sequences.
module tb_ir_nec_tx;
    localparam int U  = 4;
    localparam int CH = 1;
    localparam int F  = 192 * U;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_start = 1'b0;
    logic        tx_hold = 1'b0;
    logic        ir_out, ir_env, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    ir_nec_tx #(.UNIT_CYC(U), .CAR_HALF(CH)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start), .tx_hold(tx_hold),
        .ir_out(ir_out), .ir_env(ir_env), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          end_u;
    } vec_t;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Expected outputs j cycles after the accepting edge, from the NEC mark/space timing list.
    task automatic model(input logic [31:0] d, input int j, input int nrep,
                         output bit env, output bit outv, output bit bsy, output bit dn);
        int total, u, pos, ms[$], ml[$], base;
        total = F * (1 + nrep);
        env = 0; outv = 0;
        bsy = (j < total);
        dn  = (j == total);
        if (j >= total) return;
        if (j < F) begin
            base = 0;
            ms.push_back(0);  ml.push_back(16);
            pos = 24;
            for (int b = 0; b < 32; b++) begin
                ms.push_back(pos); ml.push_back(1);
                pos += 1 + (d[b] ? 3 : 1);
            end
            ms.push_back(pos); ml.push_back(1);
        end else begin
            base = F * ((j - F) / F + 1);
            ms.push_back(0);  ml.push_back(16);
            ms.push_back(20); ml.push_back(1);
        end
        u = (j - base) / U;
        for (int k = 0; k < ms.size(); k++) begin
            if (u >= ms[k] && u < ms[k] + ml[k]) begin
                env  = 1;
                outv = (((j - base - ms[k] * U) / CH) % 2) == 0;
            end
        end
    endtask

    // Starts a frame at the current negedge and samples ncyc cycles (j=0 is right after acceptance).
    task automatic frame(input string tag, input logic [31:0] d, input int ncyc, input int nrep,
                         input int hold_drop, input bit pester,
                         output int marks, output int last_on, output logic [31:0] dec);
        bit e, o, b, dn;
        int e_err, o_err, b_err, d_err, first_bad;
        bit hist[$];
        int rises[$];
        e_err = 0; o_err = 0; b_err = 0; d_err = 0; first_bad = -1;
        tx_data  = d;
        tx_start = 1'b1;
        tx_hold  = (hold_drop > 0);
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = $urandom;
        for (int j = 0; j < ncyc; j++) begin
            model(d, j, nrep, e, o, b, dn);
            if (ir_env !== e) e_err++;
            if (ir_out !== o) o_err++;
            if (busy !== b)   b_err++;
            if (done !== dn)  d_err++;
            if (first_bad < 0 && (ir_env !== e || ir_out !== o || busy !== b || done !== dn))
                first_bad = j;
            hist.push_back(ir_env === 1'b1);
            if (j == hold_drop) tx_hold = 1'b0;
            if (pester && (j == 10 || j == 300)) begin
                tx_start = 1'b1;
                tx_data  = ~d;
            end else begin
                tx_start = 1'b0;
            end
            if (j < ncyc - 1) @(negedge clk);
        end
        tx_start = 1'b0;
        check($sformatf("%s env_wave first_bad_cycle=%0d", tag, first_bad), e_err, 0);
        check($sformatf("%s out_wave first_bad_cycle=%0d", tag, first_bad), o_err, 0);
        check($sformatf("%s busy_wave", tag), b_err, 0);
        check($sformatf("%s done_wave", tag), d_err, 0);
        last_on = -1;
        for (int j = 0; j < ncyc && j < F; j++) begin
            if (hist[j] && (j == 0 || !hist[j-1])) rises.push_back(j);
            if (hist[j]) last_on = j;
        end
        marks = rises.size();
        dec = '0;
        for (int k = 1; k <= 32; k++)
            if (rises.size() > k + 1) dec[k-1] = (rises[k+1] - rises[k] - U) > 2 * U;
    endtask

    vec_t        vecs[6];
    int          marks, last_on, nrep;
    logic [31:0] dec, d;

    initial begin
        vecs[0] = '{32'hBA45FF00, 121};
        vecs[1] = '{32'h00000000, 89};
        vecs[2] = '{32'hFFFFFFFF, 153};
        vecs[3] = '{32'h00000001, 91};
        vecs[4] = '{32'h80000000, 91};
        vecs[5] = '{32'h12345678, 115};

        repeat (3) @(negedge clk);
        check("reset ir_out", ir_out, 0);
        check("reset ir_env", ir_env, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            frame($sformatf("vec%0d", i), vecs[i].data, F + 1, 0, 0, 0, marks, last_on, dec);
            check($sformatf("vec%0d marks", i), marks, 34);
            check($sformatf("vec%0d env_end_clk", i), last_on + 1, vecs[i].end_u * U);
            check($sformatf("vec%0d decode", i), dec, vecs[i].data);
            @(negedge clk);
        end

        for (int r = 0; r < 5; r++) begin
            d = $urandom;
            frame($sformatf("rand%0d", r), d, F + 1, 0, 0, 0, marks, last_on, dec);
            check($sformatf("rand%0d env_end_clk", r), last_on + 1, (89 + 2 * $countones(d)) * U);
            check($sformatf("rand%0d decode", r), dec, d);
            @(negedge clk);
        end

        // starts during a frame are ignored: model still expects one frame and one done
        frame("pester", 32'hBA45FF00, F + 10, 0, 0, 1, marks, last_on, dec);
        check("pester decode", dec, 32'hBA45FF00);

        // reset at unit 50 aborts immediately
        @(negedge clk);
        frame("pre_reset", 32'hBA45FF00, 50 * U, 0, 0, 0, marks, last_on, dec);
        rst_n = 1'b0;
        #1;
        check("midreset ir_out", ir_out, 0);
        check("midreset ir_env", ir_env, 0);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame("post_reset", 32'h5AA5C33C, F + 1, 0, 0, 0, marks, last_on, dec);
        check("post_reset decode", dec, 32'h5AA5C33C);

        // back-to-back: start on the done cycle's sample point is accepted on the next edge
        frame("b2b_a", 32'h00FF00FF, F + 1, 0, 0, 0, marks, last_on, dec);
        check("b2b_a done_seen", done, 1);
        frame("b2b_b", 32'hF00F0FF0, F + 1, 0, 0, 0, marks, last_on, dec);
        check("b2b_b decode", dec, 32'hF00F0FF0);

        @(negedge clk);
`ifdef IR_TX_REPEAT_EN
        nrep = 2;
`else
        nrep = 0;
`endif
        frame("hold", 32'hBA45FF00, 3 * F + 6, nrep, 2 * F + 4, 0, marks, last_on, dec);
        check("hold decode", dec, 32'hBA45FF00);

        repeat (3) @(negedge clk);
        check("final idle busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
